// File: rtl/saper_pkg.sv
// Shared board geometry, level encodings and FSM state type for the saper game.
package saper_pkg;

  localparam int EASY_SIZE   = 8;
  localparam int MEDIUM_SIZE = 10;
  localparam int HARD_SIZE   = 16;

  localparam logic [1:0] LVL_EASY   = 2'd1;
  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [4:0] size_of_level(input logic [1:0] lvl);
    case (lvl)
      LVL_EASY:   return 5'(EASY_SIZE);
      LVL_MEDIUM: return 5'(MEDIUM_SIZE);
      LVL_HARD:   return 5'(HARD_SIZE);
      default:    return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/neighbour_counter.sv
// Combinational mine count over the 8 neighbours of (x, y) inside an n x n board.
module neighbour_counter (
  input  logic [15:0][15:0] map,
  input  logic [3:0]        x,
  input  logic [3:0]        y,
  input  logic [4:0]        n,
  output logic [2:0]        count
);

  logic [3:0] raw;
  logic [4:0] nx;
  logic [4:0] ny;

  always_comb begin
    raw = '0;
    nx  = '0;
    ny  = '0;
    // An underflow at coordinate 0 wraps to 31, which the < n test rejects.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        nx = {1'b0, x} + 5'(i) - 5'd1;
        ny = {1'b0, y} + 5'(j) - 5'd1;
        if (!(i == 1 && j == 1) && (nx < n) && (ny < n))
          raw = raw + 4'(map[nx[3:0]][ny[3:0]]);
      end
    end
    if (map[x][y])
      count = 3'd0;
    else if (raw > 4'd7)
      count = 3'd7;
    else
      count = raw[2:0];
  end

endmodule

// File: rtl/mine_num_calc.sv
// Snapshots the mine map, then scans the board one cell per clock writing
// neighbour counts into the array of the latched level.
module mine_num_calc
  import saper_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  level,
  input  logic [15:0][15:0]           mine_arr,
  output logic [7:0][7:0][2:0]        num_arr_easy,
  output logic [9:0][9:0][2:0]        num_arr_medium,
  output logic [15:0][15:0][2:0]      num_arr_hard,
  output logic                        busy,
  output logic                        done
);

  state_t            state;
  logic [1:0]        lvl_q;
  logic [15:0][15:0] map_q;
  logic [3:0]        x_q;
  logic [3:0]        y_q;
  logic [4:0]        n_cur;
  logic [2:0]        cnt;
  logic              last_col;
  logic              last_cell;

  assign n_cur     = size_of_level(lvl_q);
  assign last_col  = ({1'b0, x_q} == n_cur - 5'd1);
  assign last_cell = last_col && ({1'b0, y_q} == n_cur - 5'd1);

  neighbour_counter u_counter (
    .map   (map_q),
    .x     (x_q),
    .y     (y_q),
    .n     (n_cur),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lvl_q          <= '0;
      map_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      num_arr_easy   <= '0;
      num_arr_medium <= '0;
      num_arr_hard   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && level != 2'd0) begin
            lvl_q <= level;
            map_q <= mine_arr;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          num_arr_easy   <= '0;
          num_arr_medium <= '0;
          num_arr_hard   <= '0;
          x_q            <= '0;
          y_q            <= '0;
          state          <= SCAN;
        end
        SCAN: begin
          case (lvl_q)
            LVL_EASY:   num_arr_easy[x_q[2:0]][y_q[2:0]] <= cnt;
            LVL_MEDIUM: num_arr_medium[x_q][y_q]         <= cnt;
            LVL_HARD:   num_arr_hard[x_q][y_q]           <= cnt;
            default: ;
          endcase
          if (last_cell) begin
            x_q   <= '0;
            y_q   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else if (last_col) begin
            x_q <= '0;
            y_q <= y_q + 4'd1;
          end else begin
            x_q <= x_q + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_num_calc.sv
// Scoreboard bench for mine_num_calc: stimulus queues expectations, a monitor checks each done.
module tb_mine_num_calc;
  import saper_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [1:0]             level;
  logic [15:0][15:0]      mine_arr;
  logic [7:0][7:0][2:0]   num_arr_easy;
  logic [9:0][9:0][2:0]   num_arr_medium;
  logic [15:0][15:0][2:0] num_arr_hard;
  logic                   busy;
  logic                   done;

  mine_num_calc dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .level          (level),
    .mine_arr       (mine_arr),
    .num_arr_easy   (num_arr_easy),
    .num_arr_medium (num_arr_medium),
    .num_arr_hard   (num_arr_hard),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]             lvl;
    int                     t0;
    logic [7:0][7:0][2:0]   e;
    logic [9:0][9:0][2:0]   m;
    logic [15:0][15:0][2:0] h;
    logic [3:0][3:0]        sx;
    logic [3:0][3:0]        sy;
    logic [3:0][2:0]        sv;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Scatter model: every mine bumps its in-board neighbours.
  function automatic logic [15:0][15:0][2:0] ref_counts(input logic [15:0][15:0] mp, input int n);
    int c[16][16];
    logic [15:0][15:0][2:0] r;
    r = '0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        c[x][y] = 0;
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n; y++)
        if (mp[x][y])
          for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
              if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < n && y + dy >= 0 && y + dy < n)
                c[x + dx][y + dy]++;
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n; y++)
        r[x][y] = mp[x][y] ? 3'd0 : (c[x][y] > 7 ? 3'd7 : 3'(c[x][y]));
    return r;
  endfunction

  task automatic start_run(input logic [1:0] lv, input logic [15:0][15:0] mp,
                           input logic [3:0][3:0] sx, input logic [3:0][3:0] sy,
                           input logic [3:0][2:0] sv);
    exp_t e;
    logic [15:0][15:0][2:0] r;
    int n;
    n = int'(size_of_level(lv));
    r = ref_counts(mp, n);
    e = '0;
    e.lvl = lv;
    e.sx = sx;
    e.sy = sy;
    e.sv = sv;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        if (lv == LVL_EASY && x < 8 && y < 8) e.e[x][y] = r[x][y];
        if (lv == LVL_MEDIUM && x < 10 && y < 10) e.m[x][y] = r[x][y];
        if (lv == LVL_HARD) e.h[x][y] = r[x][y];
      end
    @(negedge clk);
    level    = lv;
    mine_arr = mp;
    start    = 1'b1;
    e.t0     = cyc + 1;
    sb_q.push_back(e);
    last_exp = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) chk("done_timeout", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  exp_t       mon_e;
  logic       prev_done = 1'b0;
  int         mon_n;
  logic [3:0] px;
  logic [3:0] py;
  logic [2:0] got;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) chk("done_width", done, 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          mon_e = sb_q.pop_front();
          mon_n = int'(size_of_level(mon_e.lvl));
          chk("latency", cyc, mon_e.t0 + mon_n * mon_n + 1);
          chk("busy_in_done", busy, 1);
          chk("arr_easy", num_arr_easy, mon_e.e);
          chk("arr_medium", num_arr_medium, mon_e.m);
          chk("arr_hard", num_arr_hard, mon_e.h);
          for (int i = 0; i < 4; i++) begin
            px = mon_e.sx[i];
            py = mon_e.sy[i];
            case (mon_e.lvl)
              2'd1:    got = num_arr_easy[px[2:0]][py[2:0]];
              2'd2:    got = num_arr_medium[px][py];
              default: got = num_arr_hard[px][py];
            endcase
            chk($sformatf("spot_%0d_%0d", px, py), got, mon_e.sv[i]);
          end
        end
      end
    end
    prev_done = done;
  end

  logic [15:0][15:0] m1;
  logic [15:0][15:0] m;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    level    = 2'd0;
    mine_arr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_arrays", {num_arr_hard, num_arr_medium, num_arr_easy}, 0);
    rst = 1'b0;

    // Easy, single mine at (3,3)
    m1 = '0;
    m1[3][3] = 1'b1;
    start_run(LVL_EASY, m1, {4'd0, 4'd3, 4'd4, 4'd2}, {4'd0, 4'd3, 4'd4, 4'd2},
              {3'd0, 3'd0, 3'd1, 3'd1});
    wait_idle();

    // Hard, ring of 8 mines around (5,5); a mid-scan start must be ignored
    m = '0;
    for (int dx = 4; dx <= 6; dx++)
      for (int dy = 4; dy <= 6; dy++)
        if (!(dx == 5 && dy == 5)) m[dx][dy] = 1'b1;
    start_run(LVL_HARD, m, {4'd6, 4'd3, 4'd4, 4'd5}, {4'd3, 4'd3, 4'd4, 4'd5},
              {3'd2, 3'd1, 3'd0, 3'd7});
    repeat (19) @(negedge clk);
    level = LVL_MEDIUM;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Medium, corner mines plus one outside the 10x10 region; map toggled mid-scan
    m = '0;
    m[0][0]  = 1'b1;
    m[9][9]  = 1'b1;
    m[10][0] = 1'b1;
    start_run(LVL_MEDIUM, m, {4'd0, 4'd8, 4'd9, 4'd1}, {4'd0, 4'd8, 4'd0, 4'd0},
              {3'd0, 3'd1, 3'd0, 3'd1});
    repeat (10) @(negedge clk);
    mine_arr = '1;
    wait_idle();

    // Level 0 start is ignored
    @(negedge clk);
    level    = 2'd0;
    mine_arr = '1;
    start    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lvl0_busy", busy, 0);
    end
    start = 1'b0;
    chk("lvl0_arrays", {num_arr_hard, num_arr_medium, num_arr_easy},
        {last_exp.h, last_exp.m, last_exp.e});

    // Reset in the middle of an easy run
    start_run(LVL_EASY, m1, {4'd0, 4'd3, 4'd4, 4'd2}, {4'd0, 4'd3, 4'd4, 4'd2},
              {3'd0, 3'd0, 3'd1, 3'd1});
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_arrays", {num_arr_hard, num_arr_medium, num_arr_easy}, 0);
    repeat (2) @(negedge clk);

    // Fresh run after reset completes normally
    start_run(LVL_EASY, m1, {4'd0, 4'd3, 4'd4, 4'd2}, {4'd0, 4'd3, 4'd4, 4'd2},
              {3'd0, 3'd0, 3'd1, 3'd1});
    wait_idle();
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
